// File: rtl/cosim_reg_write_serializer.sv
// cosim_reg_write_serializer
// Packs one register-write commit record (key + value) into a stream of
// DPI-width words, least-significant word first: key words, then value words.
// Holds a single record at a time. A new record may be accepted in the same
// cycle as the last word of the previous one, so a continuous supply of
// records streams with no bubble between items.

module cosim_reg_write_serializer #(
  parameter int XREG_W         = 64,
  parameter int FREG_W         = 128,
  parameter int DPI_W          = 32,
  parameter int REG_KEY_TYPE_W = 4,
  parameter int REG_KEY_ID_W   = 60
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      in_valid_i,
  output logic                      in_ready_o,
  input  logic [REG_KEY_TYPE_W-1:0] in_key_type_i,
  input  logic [REG_KEY_ID_W-1:0]   in_key_id_i,
  input  logic [FREG_W-1:0]         in_value_i,
  output logic                      out_valid_o,
  input  logic                      out_ready_i,
  output logic [DPI_W-1:0]          out_word_o,
  output logic                      out_first_o,
  output logic                      out_last_o,
  output logic                      busy_o,
  output logic [31:0]               items_sent_o
);

  localparam int KEY_WORDS  = XREG_W / DPI_W;
  localparam int ITEM_WORDS = KEY_WORDS + FREG_W / DPI_W;
  localparam int ITEM_W     = XREG_W + FREG_W;
  localparam int IDX_W      = $clog2(ITEM_WORDS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ITEM_WORDS - 1);

  // Parameter sanity: both fields must split evenly into output words and
  // the key fields must exactly fill the integer register width.
  if (XREG_W % DPI_W != 0) begin : g_xreg_align_check
    $error("XREG_W must be a multiple of DPI_W");
  end
  if (FREG_W % DPI_W != 0) begin : g_freg_align_check
    $error("FREG_W must be a multiple of DPI_W");
  end
  if (REG_KEY_TYPE_W + REG_KEY_ID_W != XREG_W) begin : g_key_width_check
    $error("REG_KEY_TYPE_W + REG_KEY_ID_W must equal XREG_W");
  end

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  state_t              state_q;
  state_t              state_d;
  logic [IDX_W-1:0]    idx_q;
  logic [IDX_W-1:0]    idx_d;
  logic [ITEM_W-1:0]   hold_q;
  logic [31:0]         items_sent_q;
  logic                ready_raw;
  logic                load;
  logic                item_done;
  logic [DPI_W-1:0]    word_sel;

  // State, word index, holding register and item counter; reset discards any partial item.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      idx_q        <= '0;
      hold_q       <= '0;
      items_sent_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      if (load) begin
        hold_q <= {in_value_i, in_key_type_i, in_key_id_i};
      end
      if (item_done) begin
        items_sent_q <= items_sent_q + 32'd1;
      end
    end
  end

  // Next-state logic: accept in IDLE, or on the last-word handshake to chain items back to back.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    ready_raw   = 1'b0;
    load        = 1'b0;
    item_done   = 1'b0;
    out_valid_o = 1'b0;
    case (state_q)
      IDLE: begin
        ready_raw = 1'b1;
        if (in_valid_i) begin
          load    = 1'b1;
          idx_d   = '0;
          state_d = SEND;
        end
      end
      SEND: begin
        out_valid_o = 1'b1;
        if (out_ready_i) begin
          if (idx_q == LAST_IDX) begin
            item_done = 1'b1;
            ready_raw = 1'b1;
            if (in_valid_i) begin
              load  = 1'b1;
              idx_d = '0;
            end else begin
              state_d = IDLE;
            end
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Output word select from the holding register; idle cycles present zero.
  always_comb begin
    word_sel = '0;
    for (int i = 0; i < ITEM_WORDS; i++) begin
      if (idx_q == IDX_W'(i)) begin
        word_sel = hold_q[i*DPI_W +: DPI_W];
      end
    end
  end

  assign in_ready_o   = ready_raw && !rst_i;
  assign out_word_o   = out_valid_o ? word_sel : '0;
  assign out_first_o  = out_valid_o && (idx_q == '0);
  assign out_last_o   = out_valid_o && (idx_q == LAST_IDX);
  assign busy_o       = (state_q == SEND);
  assign items_sent_o = items_sent_q;

endmodule
